fetch_responder: RTL and testbench

FETCH_RESPONDER -- requirements
Module: fetch_responder

---
 rtl/fetch_responder.sv | 126 ++++++++++++
 tb/tb_fetch_responder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_responder.sv
// One-entry instruction line buffer in front of a 16-bit backing memory.
// A miss fetches two halfwords into a 32-bit line, which is updated atomically on the final ack.
module fetch_responder (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  input  logic        flush,
  output logic [31:0] fetch_opc,
  output logic        hold,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] miss_cnt,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RD_HI = 2'b01;
  localparam logic [1:0] ST_RD_LO = 2'b10;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        valid;
  logic        flush_pend;
  logic [13:0] tag;
  logic [13:0] fill_tag;
  logic [31:0] line;
  logic [15:0] asm_hi;
  logic [15:0] miss_cnt_q;
  logic        hit;
  logic        unused_addr_bits;

  // Byte offset within the word never takes part in the lookup.
  assign unused_addr_bits = ^fetch_addr[1:0];

  assign hit       = fetch_req & valid & (tag == fetch_addr[15:2]);
  assign hold      = fetch_req & ~hit;
  assign fetch_opc = line;
  assign miss_cnt  = miss_cnt_q;
  assign dbg_state = state;

  // Memory handshake: mem_rd/mem_addr stay stable from the first cycle of a
  // read until the cycle in which mem_ack is seen high; a read completes in
  // exactly the cycles where mem_rd & mem_ack. mem_ack outside a read is ignored.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = 16'h0000;
    case (state)
      ST_RD_HI: begin
        mem_rd   = 1'b1;
        mem_addr = {fill_tag, 2'b00};
      end
      ST_RD_LO: begin
        mem_rd   = 1'b1;
        mem_addr = {fill_tag, 2'b10};
      end
      default: begin
        mem_rd   = 1'b0;
        mem_addr = 16'h0000;
      end
    endcase
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = (fetch_req & ~hit) ? ST_RD_HI : ST_IDLE;
      ST_RD_HI: state_nxt = mem_ack ? ST_RD_LO : ST_RD_HI;
      ST_RD_LO: state_nxt = mem_ack ? ST_IDLE : ST_RD_LO;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state      <= ST_IDLE;
      valid      <= 1'b0;
      flush_pend <= 1'b0;
      tag        <= 14'h0000;
      fill_tag   <= 14'h0000;
      line       <= 32'h0000_0000;
      asm_hi     <= 16'h0000;
      miss_cnt_q <= 16'h0000;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (flush) begin
            valid <= 1'b0;
          end
          if (fetch_req && !hit) begin
            fill_tag <= fetch_addr[15:2];
            if (miss_cnt_q != 16'hFFFF) begin
              miss_cnt_q <= miss_cnt_q + 16'h0001;
            end
          end
        end
        ST_RD_HI: begin
          if (flush) begin
            flush_pend <= 1'b1;
          end
          if (mem_ack) begin
            asm_hi <= mem_rdata;
          end
        end
        ST_RD_LO: begin
          // A flush seen at any point of the fill poisons the line it delivers.
          if (mem_ack) begin
            line       <= {asm_hi, mem_rdata};
            tag        <= fill_tag;
            valid      <= ~(flush | flush_pend);
            flush_pend <= 1'b0;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        default: begin
          flush_pend <= flush_pend;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_responder.sv
// Bench for fetch_responder: table of fetch transactions against a behavioural
// memory with programmable ack delay, plus hand-written flush/reset/redirect sequences.
module tb_fetch_responder;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        flush;
  logic [31:0] fetch_opc;
  logic        hold;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] miss_cnt;
  logic [1:0]  dbg_state;

  int          ack_delay;
  logic        ack_noise;
  int          wait_cnt;
  int          tests_run;
  int          tests_failed;
  int          model_miss;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] addr;
    int          delay;
    int          exp_hold;
    int          exp_miss;
    logic [31:0] exp_opc;
  } vec_t;

  vec_t tbl[9];

  fetch_responder dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .flush      (flush),
    .fetch_opc  (fetch_opc),
    .hold       (hold),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .miss_cnt   (miss_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural backing memory
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0104: return 16'hA9C3;
      16'h0106: return 16'h1234;
      default:  return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endcase
  endfunction

  function automatic logic [31:0] exp_line(input logic [15:0] a);
    logic [15:0] base;
    base = {a[15:2], 2'b00};
    return {mem_word(base), mem_word(base | 16'h0002)};
  endfunction

  assign mem_rdata = mem_word(mem_addr);
  assign mem_ack   = (mem_rd && (wait_cnt >= ack_delay)) || ack_noise;

  always @(posedge clk or negedge a_rst) begin
    if (!a_rst) wait_cnt <= 0;
    else if (mem_rd && mem_ack) wait_cnt <= 0;
    else if (mem_rd) wait_cnt <= wait_cnt + 1;
  end

  // Checking helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bump_miss(input int n);
    for (int i = 0; i < n; i++) begin
      if (model_miss < 16'hFFFF) model_miss++;
    end
  endtask

  task automatic check_opc_sb(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, fetch_opc, e);
    end
  endtask

  // Advance from the current sample point until hold drops, bounded.
  task automatic wait_hit(inout int cyc);
    while (hold && cyc < 300) begin
      cyc++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc;
    logic ok;
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = v.addr;
    ack_delay  = v.delay;
    exp_q.push_back(v.exp_opc);
    bump_miss(v.exp_miss);
    #1;
    cyc = 0;
    ok  = 1'b1;
    while (hold && cyc < 300) begin
      if (cyc == 0) ok = ok & (mem_rd == 1'b0);
      else if (cyc <= v.delay + 1) ok = ok & mem_rd & (mem_addr == {v.addr[15:2], 2'b00});
      else ok = ok & mem_rd & (mem_addr == {v.addr[15:2], 2'b10});
      cyc++;
      @(negedge clk);
      #1;
    end
    check("hold_cycles", cyc, v.exp_hold);
    if (v.exp_hold > 0) check("mem_seq_stable", {31'd0, ok}, 32'd1);
    check_opc_sb("fetch_opc");
    check("miss_cnt", {16'd0, miss_cnt}, model_miss);
  endtask

  initial begin
    int   cyc;
    logic ok;
    tests_run    = 0;
    tests_failed = 0;
    model_miss   = 0;
    a_rst        = 1'b0;
    fetch_req    = 1'b1;
    fetch_addr   = 16'h0104;
    flush        = 1'b0;
    ack_delay    = 0;
    ack_noise    = 1'b0;

    tbl[0] = '{16'h0104, 0, 3, 1, 32'hA9C3_1234};
    tbl[1] = '{16'h0107, 0, 0, 0, 32'hA9C3_1234};
    tbl[2] = '{16'h0200, 3, 9, 1, exp_line(16'h0200)};
    tbl[3] = '{16'h0202, 3, 0, 0, exp_line(16'h0200)};
    tbl[4] = '{16'hFFFC, 1, 5, 1, exp_line(16'hFFFC)};
    tbl[5] = '{16'h0000, 0, 3, 1, exp_line(16'h0000)};
    tbl[6] = '{16'hFFFF, 2, 7, 1, exp_line(16'hFFFC)};
    tbl[7] = '{16'h0003, 0, 3, 1, exp_line(16'h0000)};
    tbl[8] = '{16'h0001, 0, 0, 0, exp_line(16'h0000)};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_hold_req1", {31'd0, hold}, 32'd1);
    check("rst_opc", fetch_opc, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    fetch_req = 1'b0;
    #1;
    check("rst_hold_req0", {31'd0, hold}, 32'd0);
    @(negedge clk);
    a_rst = 1'b1;

    // Table-driven transactions: cold miss, hits, slow memory, tag wrap
    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // mem_ack in IDLE is ignored
    @(negedge clk);
    fetch_req = 1'b0;
    ack_noise = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      ok = ok & ~mem_rd & ~hold & (dbg_state == 2'b00);
    end
    ack_noise = 1'b0;
    check("idle_ack_ignored", {31'd0, ok}, 32'd1);
    check("idle_ack_miss_cnt", {16'd0, miss_cnt}, model_miss);

    // Address change during a fill: 0x0200 fill completes, then 0x0300 fill
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 16'h0200; ack_delay = 0;
    @(negedge clk);
    fetch_addr = 16'h0300;
    #1;
    check("redir_c1_addr", {16'd0, mem_addr}, 32'h0200);
    check("redir_c1_hold", {31'd0, hold}, 32'd1);
    @(negedge clk); #1;
    check("redir_c2_addr", {16'd0, mem_addr}, 32'h0202);
    @(negedge clk); #1;
    check("redir_c3_line", fetch_opc, exp_line(16'h0200));
    check("redir_c3_hold", {31'd0, hold}, 32'd1);
    check("redir_c3_mem_rd", {31'd0, mem_rd}, 32'd0);
    @(negedge clk); #1;
    check("redir_c4_addr", {16'd0, mem_addr}, 32'h0300);
    @(negedge clk); #1;
    check("redir_c5_addr", {16'd0, mem_addr}, 32'h0302);
    cyc = 5;
    wait_hit(cyc);
    check("redir_hit_cycle", cyc, 6);
    exp_q.push_back(exp_line(16'h0300));
    check_opc_sb("redir_opc");
    bump_miss(2);
    check("redir_miss_cnt", {16'd0, miss_cnt}, model_miss);

    // Hit on the old line while a fill is in flight keeps old data
    @(negedge clk);
    fetch_addr = 16'h0400; ack_delay = 2;
    ok = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      fetch_addr = 16'h0301;
      #1;
      ok = ok & ~hold & (fetch_opc == exp_line(16'h0300));
    end
    check("atomic_old_hits", {31'd0, ok}, 32'd1);
    @(negedge clk); #1;
    check("atomic_new_line", fetch_opc, exp_line(16'h0400));
    check("atomic_c7_hold", {31'd0, hold}, 32'd1);
    cyc = 7;
    wait_hit(cyc);
    check("atomic_hit_cycle", cyc, 14);
    bump_miss(2);
    check("atomic_miss_cnt", {16'd0, miss_cnt}, model_miss);

    // Flush pulsed in RD_LO before the final ack
    @(negedge clk);
    fetch_addr = 16'h0500; ack_delay = 2;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    cyc = 5;
    wait_hit(cyc);
    check("flush_rdlo_hit_cycle", cyc, 14);
    exp_q.push_back(exp_line(16'h0500));
    check_opc_sb("flush_rdlo_opc");
    bump_miss(2);
    check("flush_rdlo_miss_cnt", {16'd0, miss_cnt}, model_miss);

    // Flush in the same cycle as the final ack
    @(negedge clk);
    fetch_addr = 16'h0600; ack_delay = 0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_ack_c3_hold", {31'd0, hold}, 32'd1);
    cyc = 3;
    wait_hit(cyc);
    check("flush_ack_hit_cycle", cyc, 6);
    bump_miss(2);
    check("flush_ack_miss_cnt", {16'd0, miss_cnt}, model_miss);

    // Flush in IDLE with a simultaneous hit
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_idle_hold", {31'd0, hold}, 32'd0);
    check("flush_idle_opc", fetch_opc, exp_line(16'h0600));
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle_after", {31'd0, hold}, 32'd1);
    cyc = 1;
    wait_hit(cyc);
    check("flush_idle_hit_cycle", cyc, 4);
    bump_miss(1);

    // Reset asserted in RD_HI
    @(negedge clk);
    fetch_addr = 16'h0800; ack_delay = 3;
    @(negedge clk);
    fetch_addr = 16'h0600;
    #1;
    check("rstfill_old_hit", {31'd0, hold}, 32'd0);
    check("rstfill_mem_rd_before", {31'd0, mem_rd}, 32'd1);
    #1;
    a_rst = 1'b0;
    #1;
    check("rstfill_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rstfill_valid_gone", {31'd0, hold}, 32'd1);
    check("rstfill_state", {30'd0, dbg_state}, 32'd0);
    check("rstfill_opc", fetch_opc, 32'd0);
    check("rstfill_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    model_miss = 0;
    @(negedge clk);
    a_rst = 1'b1;
    ack_delay = 0;
    #1;
    cyc = 0;
    wait_hit(cyc);
    check("rstfill_refill_cycle", cyc, 3);
    bump_miss(1);
    check("rstfill_refill_miss", {16'd0, miss_cnt}, model_miss);

    // Saturation: preload the counter near the top, then keep missing
    @(negedge clk);
    dut.miss_cnt_q = 16'hFFFD;
    model_miss = 16'hFFFD;
    for (int i = 1; i <= 4; i++) begin
      vec_t v;
      v = '{16'(i * 16'h1000), 0, 3, 1, exp_line(16'(i * 16'h1000))};
      run_vec(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
